cnn_conv_acc_sat: RTL and testbench

- Downstream consumer of the conv1 signed multiplier (10-bit signed × 14-bit signed → 25-bit signed product).
- Accumulates one kernel window of products plus bias, then applies rounding, a right shift and saturation.
- Emits one 10-bit signed activation per window, ready to drive the next layer's 10-bit multiplier operand.
- Uses valid/ready handshakes on both sides and holds one result buffered under backpressure.

---
 rtl/cnn_conv_acc_sat_if.sv | 25 ++
 rtl/cnn_conv_acc_sat.sv | 124 ++++++++++++
 tb/tb_cnn_conv_acc_sat.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_acc_sat_if.sv
// Handshake bundle between the conv1 multiplier, the accumulate/saturate stage
// and the next layer: a product stream in, one activation per window out.
interface cnn_conv_acc_sat_if #(
  parameter int PROD_WIDTH = 25,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 10
);
  logic                         prod_vld;
  logic                         prod_rdy;
  logic signed [PROD_WIDTH-1:0] prod_data;
  logic signed [ACC_WIDTH-1:0]  bias;
  logic                         out_vld;
  logic                         out_rdy;
  logic signed [OUT_WIDTH-1:0]  out_data;

  modport master (
    output prod_vld, prod_data, bias, out_rdy,
    input  prod_rdy, out_vld, out_data
  );

  modport slave (
    input  prod_vld, prod_data, bias, out_rdy,
    output prod_rdy, out_vld, out_data
  );
endinterface

// File: rtl/cnn_conv_acc_sat.sv
// Accumulates KERNEL_LEN signed products plus bias, then rounds, shifts and
// saturates to one OUT_WIDTH activation. Define CNN_ACC_RELU_EN to fuse a ReLU.
module cnn_conv_acc_sat #(
  parameter int PROD_WIDTH = 25,
  parameter int ACC_WIDTH  = 32,
  parameter int KERNEL_LEN = 9,
  parameter int SHIFT      = 8,
  parameter int OUT_WIDTH  = 10
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  cnn_conv_acc_sat_if.slave bus,
  output logic              busy
);

  localparam int CNT_WIDTH = $clog2(KERNEL_LEN + 1);
  localparam int EXT_WIDTH = ACC_WIDTH + 1;
  localparam int MAX_INT   = 2 ** (OUT_WIDTH - 1) - 1;
  localparam int MIN_INT   = -(2 ** (OUT_WIDTH - 1));

  localparam logic signed [EXT_WIDTH-1:0] RND_ADD = EXT_WIDTH'(2 ** (SHIFT - 1));
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'(MAX_INT);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = EXT_WIDTH'(MIN_INT);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(MAX_INT);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = OUT_WIDTH'(MIN_INT);

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_val;
  logic [CNT_WIDTH-1:0]         count;
  logic signed [EXT_WIDTH-1:0]  acc_ext;
  logic signed [EXT_WIDTH-1:0]  rounded;
  logic signed [OUT_WIDTH-1:0]  sat;
  logic signed [OUT_WIDTH-1:0]  result;
  logic                         hs;

  assign hs       = bus.prod_vld & bus.prod_rdy;
  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
  assign bias_val = bus.bias;

  // One guard bit keeps the rounding add from wrapping at the top of the range.
  assign acc_ext = {acc[ACC_WIDTH-1], acc};
  assign rounded = (acc_ext + RND_ADD) >>> SHIFT;

  always_comb begin
    sat = rounded[OUT_WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      sat = OUT_MAX;
    end else if (rounded < SAT_MIN) begin
      sat = OUT_MIN;
    end
  end

`ifdef CNN_ACC_RELU_EN
  assign result = sat[OUT_WIDTH-1] ? '0 : sat;
`else
  assign result = sat;
`endif

  // prod_rdy, busy and out_vld are registered alongside the state so no
  // handshake output has a combinational path from the inputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      bus.prod_rdy <= 1'b0;
      bus.out_vld  <= 1'b0;
      bus.out_data <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.prod_rdy <= 1'b1;
          if (hs) begin
            acc   <= bias_val + prod_ext;
            count <= CNT_WIDTH'(1);
            busy  <= 1'b1;
            if (KERNEL_LEN == 1) begin
              state        <= ROUND;
              bus.prod_rdy <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (hs) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_WIDTH'(1);
            if (count == CNT_WIDTH'(KERNEL_LEN - 1)) begin
              state        <= ROUND;
              bus.prod_rdy <= 1'b0;
            end
          end
        end
        ROUND: begin
          bus.out_data <= result;
          bus.out_vld  <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (bus.out_rdy) begin
            bus.out_vld  <= 1'b0;
            bus.prod_rdy <= 1'b1;
            busy         <= 1'b0;
            count        <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.prod_rdy <= 1'b0;
          bus.out_vld  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_acc_sat.sv
// Randomized self-checking bench for cnn_conv_acc_sat; expected activations come
// from a plain-integer model of sum, round-half-up division, clamp (and ReLU).
module tb_cnn_conv_acc_sat;

  localparam int PROD_W = 25;
  localparam int ACC_W  = 32;
  localparam int K      = 9;
  localparam int SH     = 8;
  localparam int OUT_W  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   hs_cycle = 0;
  int   checks = 0;
  int   passes = 0;
  longint prods[K];

  cnn_conv_acc_sat_if #(.PROD_WIDTH(PROD_W), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) bus ();

  cnn_conv_acc_sat #(
    .PROD_WIDTH(PROD_W), .ACC_WIDTH(ACC_W), .KERNEL_LEN(K), .SHIFT(SH), .OUT_WIDTH(OUT_W)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference: exact sum, divide by 2^SH rounding half toward +inf, clamp.
  function automatic longint model(input longint b);
    longint s, q, r, lo, hi;
    s = b;
    foreach (prods[i]) s += prods[i];
    q = s + (longint'(1) << (SH - 1));
    if (q >= 0) r = q / (longint'(1) << SH);
    else        r = -((-q + (longint'(1) << SH) - 1) / (longint'(1) << SH));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`ifdef CNN_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic feed(input int n, input int max_gap, input longint b);
    int t;
    for (int i = 0; i < n; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus.prod_vld  = 1'b0;
        bus.prod_data = PROD_W'($urandom);
      end
      @(negedge clk);
      bus.prod_vld  = 1'b1;
      bus.prod_data = PROD_W'(prods[i]);
      bus.bias      = (i == 0) ? ACC_W'(b) : ACC_W'($urandom);
      t = 0;
      while (!bus.prod_rdy && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checkOutput("prod_rdy_timeout", 0, 1);
        bus.prod_vld = 1'b0;
        return;
      end
      hs_cycle = cyc;
    end
    @(negedge clk);
    bus.prod_vld = 1'b0;
  endtask

  // Sends one window, then checks latency, result and (optionally) backpressure.
  task automatic applyStimulus(input string tag, input longint b, input int max_gap, input int hold);
    int t;
    longint exp_val;
    exp_val = model(b);
    bus.out_rdy = (hold == 0);
    feed(K, max_gap, b);
    t = 0;
    while (!bus.out_vld && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checkOutput({tag, "_out_vld_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_latency"}, cyc - hs_cycle, 2);
    checkOutput({tag, "_data"}, bus.out_data, exp_val);
    checkOutput({tag, "_rdy_low"}, bus.prod_rdy, 0);
    checkOutput({tag, "_busy"}, busy, 1);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        bus.prod_vld  = 1'b1;
        bus.prod_data = PROD_W'($urandom);
        checkOutput({tag, "_bp_vld"}, bus.out_vld, 1);
        checkOutput({tag, "_bp_data"}, bus.out_data, exp_val);
        checkOutput({tag, "_bp_rdy"}, bus.prod_rdy, 0);
      end
      bus.prod_vld = 1'b0;
      bus.out_rdy  = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, "_vld_drop"}, bus.out_vld, 0);
    checkOutput({tag, "_rdy_back"}, bus.prod_rdy, 1);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic fillConst(input longint v);
    foreach (prods[i]) prods[i] = v;
  endtask

  initial begin
    longint sat_neg;
    bus.prod_vld  = 1'b0;
    bus.prod_data = '0;
    bus.bias      = '0;
    bus.out_rdy   = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_prod_rdy", bus.prod_rdy, 0);
    checkOutput("rst_out_vld", bus.out_vld, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_prod_rdy", bus.prod_rdy, 1);

    fillConst(256);
    applyStimulus("basic", 0, 0, 0);
    checkOutput("basic_const", model(0), 9);

    fillConst(0);
    prods[0] = 256;
    applyStimulus("round_bias", 128, 0, 0);
    checkOutput("round_bias_const", model(128), 2);

    fillConst(0);
    applyStimulus("neg_bias", -384, 0, 0);
    checkOutput("neg_bias_const", model(-384), -1);

    fillConst(65536);
    applyStimulus("sat_pos", 0, 0, 0);
    checkOutput("sat_pos_const", model(0), 511);

`ifdef CNN_ACC_RELU_EN
    sat_neg = 0;
`else
    sat_neg = -512;
`endif
    fillConst(-65536);
    applyStimulus("sat_neg", 0, 0, 0);
    checkOutput("sat_neg_const", model(0), sat_neg);

    fillConst(256);
    applyStimulus("backpressure", 0, 0, 5);
    applyStimulus("bubbles", 0, 4, 0);

    // Abort a window after four products with an asynchronous reset pulse.
    fillConst(256);
    feed(4, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_prod_rdy", bus.prod_rdy, 0);
    checkOutput("mid_rst_out_vld", bus.out_vld, 0);
    checkOutput("mid_rst_out_data", bus.out_data, 0);
    checkOutput("mid_rst_busy", busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus("after_rst", 0, 0, 0);

    for (int w = 0; w < 16; w++) begin
      int mode = int'($urandom_range(2, 0));
      longint range = (mode == 0) ? 4096 : (mode == 1) ? 65536 : 16777216;
      longint b = longint'($urandom_range(0, 1 << 27)) - (1 << 26);
      if (mode == 0) b = longint'($urandom_range(0, 2048)) - 1024;
      foreach (prods[i]) prods[i] = longint'($urandom_range(0, 32'(2 * range - 1))) - range;
      applyStimulus("random", b, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
